ifq_buffer: RTL and testbench
=============================

# ifq_buffer

Instruction fetch queue storage: a circular buffer between the instruction cache read port and the decode stage, driven by the IFQ control FSM. It stores fetched instruction words on `push` and presents the head word on `pop`. It reports `empty`/`full` back to the controller as `fifo_empty`/`fifo_full` and `dout_valid` to decode. It also supports a same-cycle cache-to-decode bypass when the queue is empty, and a branch flush.

## Interface
Parameters:
- `DATA_W`, 32, instruction word width
- `DEPTH`, 16, number of entries; power of two, ≥ 4
- `ADDR_W`, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `din`  in  DATA_W  instruction word from cache
- `push`  in  1  write `din` into the tail
- `pop`  in  1  read the head to `dout`
- `bypass`  in  1  forward `din` straight to `dout` when empty
- `flush`  in  1  branch flush; discard all contents
- `dout`  out  DATA_W  registered instruction to decode
- `dout_valid`  out  1  `dout` updated this cycle
- `empty`  out  1  count == 0 (combinational from registers)
- `full`  out  1  count == DEPTH
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH
- `overflow`  out  1  sticky: a push was dropped while full

## Operation
- Storage is DEPTH entries, with `wr_ptr`/`rd_ptr` of ADDR_W bits that wrap modulo DEPTH. `count` is a separate ADDR_W+1-bit counter.
- Accepted push (`push_ok`) = push & (~full | pop_ok). Dropped push = push & full & ~pop. A dropped push sets `overflow`.
- Accepted pop (`pop_ok`) = pop & ~empty. The pop loads the head entry into `dout`, increments `rd_ptr`, and sets `dout_valid`=1 for the next cycle.
- Pop while empty: no pointer change, `dout_valid`=0, `dout` holds.
- Push and pop in the same cycle:
  - non-empty: both are performed; `count` is unchanged, including when full.
  - empty (without bypass): only the push is performed; `count`=1.
- Bypass (with the macro defined): when bypass & push & pop & empty, `din` is loaded into `dout` and `dout_valid`=1. Nothing is stored; pointers and `count` are unchanged.
- `bypass` while non-empty is ignored, and normal push/pop rules apply. This preserves ordering.
- `flush` has priority over push, pop and bypass in the same cycle. Next cycle:
  - pointers = 0, `count` = 0, `dout_valid` = 0, `overflow` = 0;
  - `dout` holds its old value.
- `count` update: +1 on push_ok & ~pop_ok, −1 on pop_ok & ~push_ok, otherwise unchanged.
- `dout_valid` is a one-cycle pulse per accepted pop or bypass. It is never asserted for two entries at once.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0, pointers=0.
- Reset asserted mid-operation clears all state immediately (asynchronous). Contents are not cleared but are unreachable.
- Push-to-visible latency: a word pushed in cycle N can be popped in N+1 and appears on `dout` in N+2.
- Bypass latency: `din` in cycle N appears on `dout` with `dout_valid` in N+1.
- `empty`, `full` and `count` reflect the registered state after the edge. The controller samples them in the following cycle.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- `IFQ_BYPASS_EN` defined: bypass path as described above.
- Not defined: the `bypass` port is still present but ignored. Push+pop on empty stores the word, and decode sees it after the normal 2-cycle latency.

## Structure
- Package `ifq_pkg`:
  - `IFQ_DATA_W`, `IFQ_DEPTH` constants;
  - `typedef logic [IFQ_DATA_W-1:0] instr_t`;
  - pointer typedef.
- Sub-module `ifq_mem`: DEPTH×DATA_W array with one synchronous write port and one asynchronous read port (address = `rd_ptr`).
- Pointers, count, flags and the output register live in `ifq_buffer`.

## Test plan
- Reset, then push 0x11111111, 0x22222222, then pop twice → `dout` = 0x11111111 then 0x22222222 on consecutive `dout_valid` pulses; `count` goes 0→1→2→1→0.
- Push 16 words (DEPTH=16) → `full`=1. A 17th push alone is dropped, `overflow`=1, `count`=16. Push+pop while full → `count` stays 16 and FIFO order is preserved across the pointer wrap.
- Empty queue, bypass+push+pop with `din`=0xCAFEF00D → next cycle `dout`=0xCAFEF00D, `dout_valid`=1, `count`=0. Without `IFQ_BYPASS_EN` → `count`=1, `dout_valid`=0.
- 5 entries stored, flush together with push+pop → next cycle `count`=0, `empty`=1, `dout_valid`=0, `overflow`=0.
- Pop on empty → `dout_valid`=0 and `dout` unchanged. Reset asserted mid-stream with `count`=7 → `count`=0, `empty`=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared constants and types for the instruction fetch queue.
package ifq_pkg;

  localparam int unsigned IFQ_DATA_W = 32;
  localparam int unsigned IFQ_DEPTH  = 16;
  localparam int unsigned IFQ_ADDR_W = $clog2(IFQ_DEPTH);

  typedef logic [IFQ_DATA_W-1:0] instr_t;
  typedef logic [IFQ_ADDR_W-1:0] ifq_ptr_t;
  typedef logic [IFQ_ADDR_W:0]   ifq_cnt_t;

  // True when n is a power of two and at least 4.
  function automatic bit ifq_depth_ok(input int unsigned n);
    return (n >= 4) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/ifq_mem.sv
// Instruction fetch queue storage: one synchronous write port and one
// asynchronous read port. Contents are never reset; reachability is
// governed by the pointers in ifq_buffer.
module ifq_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write the tail entry on an accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ifq_buffer.sv
// Instruction fetch queue: circular buffer between the I-cache read port and
// decode. Pointers, occupancy count, status flags and the registered output
// live here; storage is in ifq_mem.
// Optional feature: define IFQ_BYPASS_EN to enable the empty-queue
// cache-to-decode bypass. Without it the bypass input is ignored.
module ifq_buffer
  import ifq_pkg::*;
#(
  parameter int unsigned DATA_W = IFQ_DATA_W,
  parameter int unsigned DEPTH  = IFQ_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              push,
  input  logic              pop,
  input  logic              bypass,
  input  logic              flush,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              overflow_q, overflow_d;

  logic              pop_ok;
  logic              push_ok;
  logic              push_drop;
  logic              bypass_hit;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

`ifdef IFQ_BYPASS_EN
  // Bypass only when nothing is queued, so ordering is preserved.
  assign bypass_hit = bypass & push & pop & empty;
`else
  logic unused_bypass;
  assign unused_bypass = bypass;
  assign bypass_hit    = 1'b0;
`endif

  assign pop_ok    = pop & ~empty & ~bypass_hit;
  // When full, a simultaneous pop frees the slot the push writes into.
  assign push_ok   = push & (~full | pop_ok) & ~bypass_hit;
  assign push_drop = push & full & ~pop;
  assign mem_we    = push_ok & ~flush;

  ifq_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // Next-state for pointers, count, flags and output register; flush wins.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = overflow_q;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (bypass_hit) begin
        dout_d       = din;
        dout_valid_d = 1'b1;
      end
      if (pop_ok) begin
        dout_d       = mem_rdata;
        dout_valid_d = 1'b1;
        rd_ptr_d     = rd_ptr_q + ADDR_W'(1);
      end
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
        count_d = count_q - CNT_W'(1);
      end
      if (push_drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign count      = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ifq_buffer.sv
// Self-checking bench for ifq_buffer against a queue-based reference model.
// Honours IFQ_BYPASS_EN the same way as the design build.
module tb_ifq_buffer;

  localparam int DEPTH = 16;

  logic        clk;
  logic        reset;
  logic [31:0] din;
  logic        push;
  logic        pop;
  logic        bypass;
  logic        flush;
  logic [31:0] dout;
  logic        dout_valid;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic        overflow;

  int checks;
  int failures;

  // Reference model state.
  logic [31:0] q_m[$];
  logic [31:0] dout_m;
  logic        dv_m;
  logic        ovf_m;

  ifq_buffer u_dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .push       (push),
    .pop        (pop),
    .bypass     (bypass),
    .flush      (flush),
    .dout       (dout),
    .dout_valid (dout_valid),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 32'(count), 32'(q_m.size()));
    check({tag, ".empty"}, 32'(empty), 32'(q_m.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(q_m.size() == DEPTH));
    check({tag, ".dout_valid"}, 32'(dout_valid), 32'(dv_m));
    check({tag, ".dout"}, dout, dout_m);
    check({tag, ".overflow"}, 32'(overflow), 32'(ovf_m));
  endtask

  task automatic model_reset();
    q_m.delete();
    dout_m = '0;
    dv_m   = 1'b0;
    ovf_m  = 1'b0;
  endtask

  // One clock: drive, update the model at the edge, check just after it.
  task automatic step(input string tag, input logic p, input logic o, input logic b,
                      input logic f, input logic [31:0] d);
    bit was_empty;
    bit was_full;
    bit byp;
    push = p; pop = o; bypass = b; flush = f; din = d;
    @(posedge clk);
    was_empty = (q_m.size() == 0);
    was_full  = (q_m.size() == DEPTH);
    if (f) begin
      q_m.delete();
      dv_m  = 1'b0;
      ovf_m = 1'b0;
    end else begin
`ifdef IFQ_BYPASS_EN
      byp = b && p && o && was_empty;
`else
      byp = 1'b0;
`endif
      if (byp) begin
        dout_m = d;
        dv_m   = 1'b1;
      end else begin
        if (o && !was_empty) begin
          dout_m = q_m.pop_front();
          dv_m   = 1'b1;
        end else begin
          dv_m = 1'b0;
        end
        if (p && (!was_full || o)) q_m.push_back(d);
        if (p && was_full && !o) ovf_m = 1'b1;
      end
    end
    #1;
    check_all(tag);
    push = 0; pop = 0; bypass = 0; flush = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    push = 0; pop = 0; bypass = 0; flush = 0; din = '0;
    reset = 1'b0;
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // Two pushes then two pops.
    step("tp1_push1", 1, 0, 0, 0, 32'h1111_1111);
    step("tp1_push2", 1, 0, 0, 0, 32'h2222_2222);
    step("tp1_pop1", 0, 1, 0, 0, '0);
    check("tp1_dout1", dout, 32'h1111_1111);
    step("tp1_pop2", 0, 1, 0, 0, '0);
    check("tp1_dout2", dout, 32'h2222_2222);
    check("tp1_count_end", 32'(count), 32'd0);
    step("tp1_idle", 0, 0, 0, 0, '0);

    // Fill, overflow, push+pop while full across the pointer wrap, drain.
    for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, 0, 0, 32'h1000 + 32'(i));
    check("fill_full", 32'(full), 32'd1);
    step("drop", 1, 0, 0, 0, 32'hDEAD_BEEF);
    check("drop_overflow", 32'(overflow), 32'd1);
    check("drop_count", 32'(count), 32'd16);
    for (int i = 0; i < 20; i++) step("full_pp", 1, 1, 0, 0, $urandom);
    for (int i = 0; i < 11; i++) step("drain", 0, 1, 0, 0, '0);

    // Five stored, flush together with push+pop.
    step("flush", 1, 1, 1, 1, 32'h5555_5555);
    check("flush_count", 32'(count), 32'd0);
    check("flush_ovf", 32'(overflow), 32'd0);

    // Bypass on empty queue.
    step("bypass", 1, 1, 1, 0, 32'hCAFE_F00D);
`ifdef IFQ_BYPASS_EN
    check("bypass_dout", dout, 32'hCAFE_F00D);
    check("bypass_count", 32'(count), 32'd0);
`else
    check("nobypass_count", 32'(count), 32'd1);
    check("nobypass_dv", 32'(dout_valid), 32'd0);
`endif
    step("flush2", 0, 0, 0, 1, '0);

    // Pop on empty holds dout.
    step("pop_empty", 0, 1, 0, 0, '0);
    check("pop_empty_dv", 32'(dout_valid), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step("rand", 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 99) < 3), $urandom);
    end

    // Asynchronous reset mid-stream with seven entries.
    step("pre_rst_flush", 0, 0, 0, 1, '0);
    for (int i = 0; i < 7; i++) step("pre_rst", 1, 0, 0, 0, $urandom);
    check("pre_rst_count", 32'(count), 32'd7);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_empty", 32'(empty), 32'd1);
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b1;
    step("post_rst_push", 1, 0, 0, 0, 32'hABCD_0123);
    step("post_rst_pop", 0, 1, 0, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
